syndrome_round_sequencer: RTL

Sequences one full error-correction round for the 5-qubit code.
- Requests ancilla syndrome measurements per axis in the order X, Y, Z.
- Repeats each measurement until ROUNDS consecutive identical syndromes agree, which filters measurement faults.
- Drives the syndrome-to-correction LUT for each agreed syndrome, collects the three 5-bit corrections and hands them to the host over a valid/ready interface.
- Sits between the host controller, the ancilla readout front-end and the correction LUT.

---
 rtl/syndrome_round_sequencer_if.sv | 20 ++
 rtl/syndrome_round_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/syndrome_round_sequencer_if.sv
// syndrome_round_sequencer_if: host, ancilla readout and correction LUT signals of one round sequencer.
// master = the sequencer, slave = its environment (host, readout front-end, LUT).
interface syndrome_round_sequencer_if;
    logic       start, busy, out_valid, out_ready;
    logic       meas_req, meas_valid, lut_req, err_timeout;
    logic [1:0] meas_axis, lut_axis;
    logic [3:0] meas_syndrome, lut_syndrome;
    logic [4:0] lut_correction, corr_x, corr_y, corr_z;
    logic [2:0] err_unstable;
    modport master (
        input  start, meas_valid, meas_syndrome, lut_correction, out_ready,
        output busy, meas_req, meas_axis, lut_req, lut_axis, lut_syndrome,
               out_valid, corr_x, corr_y, corr_z, err_timeout, err_unstable
    );
    modport slave (
        output start, meas_valid, meas_syndrome, lut_correction, out_ready,
        input  busy, meas_req, meas_axis, lut_req, lut_axis, lut_syndrome,
               out_valid, corr_x, corr_y, corr_z, err_timeout, err_unstable
    );
endinterface

// File: rtl/syndrome_round_sequencer.sv
// syndrome_round_sequencer: runs one X/Y/Z syndrome round with repeat-until-agree filtering and LUT decode.
module syndrome_round_sequencer #(
    parameter int ROUNDS    = 2,
    parameter int MAX_TRIES = 6,
    parameter int TIMEOUT   = 16,
    parameter int LUT_LAT   = 3
) (
    input logic                        clk,
    input logic                        rst,
    syndrome_round_sequencer_if.master bus
);
    localparam logic [2:0] L_ROUNDS  = 3'(ROUNDS);
    localparam logic [3:0] L_TRIES   = 4'(MAX_TRIES);
    localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT);
    localparam logic [2:0] L_LAT_END = 3'(LUT_LAT - 1);

    typedef enum logic [2:0] {IDLE, MEAS, DEC_REQ, DEC_WAIT, DONE} state_t;

    state_t          r_state, w_state;
    logic [1:0]      r_axis, w_axis;
    logic [3:0]      r_tries, w_tries, w_tries_nx, r_synd, w_synd;
    logic [2:0]      r_agree, w_agree, w_agree_nx, r_lat, w_lat;
    logic [7:0]      r_wait, w_wait;
    logic [2:0][4:0] r_corr, w_corr;
    logic            r_to, w_to;
    logic [2:0]      r_un, w_un;
    logic            w_dec;

    always_comb begin
        w_state    = r_state;
        w_axis     = r_axis;
        w_tries    = r_tries;
        w_agree    = r_agree;
        w_synd     = r_synd;
        w_wait     = r_wait;
        w_lat      = r_lat;
        w_corr     = r_corr;
        w_to       = r_to;
        w_un       = r_un;
        w_tries_nx = r_tries + 4'd1;
        // agree==0 means nothing stored yet for this axis
        w_agree_nx = (r_agree != 3'd0 && bus.meas_syndrome == r_synd) ? r_agree + 3'd1 : 3'd1;
        case (r_state)
            IDLE: if (bus.start) begin
                w_state = MEAS;
                w_axis  = 2'b01;
                w_tries = '0;
                w_agree = '0;
                w_synd  = '0;
                w_wait  = '0;
                w_lat   = '0;
                w_corr  = '0;
                w_to    = 1'b0;
                w_un    = '0;
            end
            MEAS: if (bus.meas_valid) begin
                w_tries = w_tries_nx;
                w_agree = w_agree_nx;
                w_synd  = bus.meas_syndrome;
                w_wait  = '0;
                if (w_agree_nx == L_ROUNDS) begin
                    w_state = DEC_REQ;
                end else if (w_tries_nx == L_TRIES) begin
                    w_un[r_axis - 2'd1] = 1'b1;
                    w_axis  = r_axis + 2'd1;
                    w_tries = '0;
                    w_agree = '0;
                    w_state = (r_axis == 2'b11) ? DONE : MEAS;
                end
            end else begin
                w_wait = r_wait + 8'd1;
                if (w_wait == L_TIMEOUT) begin
                    w_to    = 1'b1;
                    w_corr  = '0;
                    w_state = DONE;
                end
            end
            DEC_REQ: begin
                w_lat   = '0;
                w_state = DEC_WAIT;
            end
            DEC_WAIT: begin
                w_lat = r_lat + 3'd1;
                if (r_lat == L_LAT_END) begin
                    w_corr[r_axis - 2'd1] = bus.lut_correction;
                    w_axis  = r_axis + 2'd1;
                    w_tries = '0;
                    w_agree = '0;
                    w_wait  = '0;
                    w_state = (r_axis == 2'b11) ? DONE : MEAS;
                end
            end
            DONE: w_state = bus.out_ready ? IDLE : DONE;
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_axis  <= '0;
            r_tries <= '0;
            r_agree <= '0;
            r_synd  <= '0;
            r_wait  <= '0;
            r_lat   <= '0;
            r_corr  <= '0;
            r_to    <= 1'b0;
            r_un    <= '0;
        end else begin
            r_state <= w_state;
            r_axis  <= w_axis;
            r_tries <= w_tries;
            r_agree <= w_agree;
            r_synd  <= w_synd;
            r_wait  <= w_wait;
            r_lat   <= w_lat;
            r_corr  <= w_corr;
            r_to    <= w_to;
            r_un    <= w_un;
        end
    end

    assign w_dec            = r_state == DEC_REQ || r_state == DEC_WAIT;
    assign bus.busy         = r_state != IDLE;
    assign bus.meas_req     = r_state == MEAS;
    assign bus.meas_axis    = bus.meas_req ? r_axis : 2'b00;
    assign bus.lut_req      = r_state == DEC_REQ;
    assign bus.lut_axis     = w_dec ? r_axis : 2'b00;
    assign bus.lut_syndrome = w_dec ? r_synd : 4'd0;
    assign bus.out_valid    = r_state == DONE;
    assign bus.corr_x       = r_corr[0];
    assign bus.corr_y       = r_corr[1];
    assign bus.corr_z       = r_corr[2];
    assign bus.err_timeout  = r_to;
    assign bus.err_unstable = r_un;
endmodule
